// File: rtl/bht_predictor_if.sv
// ============================================================================
// Module      : bht_predictor_if
// Description : Lookup/training bundle for the branch history table
//               predictor. The master issues lookups and training updates;
//               the slave (the predictor) returns registered lookup results
//               and the global history register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bht_predictor_if #(
  parameter int CTR_W = 2,
  parameter int IDX_W = 5
);
  // Lookup request and registered result
  logic             predict_valid;
  logic [IDX_W-1:0] predict_pc;
  logic             predict_ready;
  logic             predict_taken;
  logic [CTR_W-1:0] predict_state;
  logic [IDX_W-1:0] predict_history;

  // Training request
  logic             train_valid;
  logic [IDX_W-1:0] train_pc;
  logic             train_taken;
  logic             train_mispredicted;
  logic [IDX_W-1:0] train_history;

  // Current global history register
  logic [IDX_W-1:0] history;

  modport master (
    output predict_valid, predict_pc,
    output train_valid, train_pc, train_taken, train_mispredicted, train_history,
    input  predict_ready, predict_taken, predict_state, predict_history,
    input  history
  );

  modport slave (
    input  predict_valid, predict_pc,
    input  train_valid, train_pc, train_taken, train_mispredicted, train_history,
    output predict_ready, predict_taken, predict_state, predict_history,
    output history
  );
endinterface

`default_nettype wire

// File: rtl/bht_predictor.sv
// ============================================================================
// Module      : bht_predictor
// Description : Branch history table of 2**IDX_W saturating counters with a
//               global history register. Lookups are registered and read the
//               table before any same-edge training write.
//               Optional feature: define BHT_PREDICTOR_GSHARE_EN to index the
//               table with (pc XOR history) for both lookup and training.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bht_predictor #(
  parameter int CTR_W = 2,
  parameter int IDX_W = 5
) (
  input  wire logic     clk,
  input  wire logic     areset_n,
  bht_predictor_if.slave bus
);

  localparam int DEPTH = 2 ** IDX_W;

  // Weakly not-taken: one below the taken threshold
  localparam logic [CTR_W-1:0] C_CTR_RST = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] C_CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] C_CTR_MIN = '0;

  logic [DEPTH-1:0][CTR_W-1:0] table_q;
  logic [IDX_W-1:0]            history_q;
  logic [IDX_W-1:0]            history_d;
  logic                        ready_q;
  logic                        taken_q;
  logic [CTR_W-1:0]            state_q;
  logic [IDX_W-1:0]            phist_q;

  logic [IDX_W-1:0]            w_pidx;
  logic [IDX_W-1:0]            w_tidx;
  logic [CTR_W-1:0]            w_ctr_cur;
  logic [CTR_W-1:0]            w_ctr_d;
  logic [CTR_W-1:0]            w_lookup;

`ifdef BHT_PREDICTOR_GSHARE_EN
  assign w_pidx = bus.predict_pc ^ history_q;
  assign w_tidx = bus.train_pc ^ bus.train_history;
`else
  assign w_pidx = bus.predict_pc;
  assign w_tidx = bus.train_pc;
`endif

  assign w_lookup  = table_q[w_pidx];
  assign w_ctr_cur = table_q[w_tidx];

  // Saturating counter step and next global history
  always_comb begin
    w_ctr_d   = w_ctr_cur;
    history_d = history_q;
    if (bus.train_taken) begin
      if (w_ctr_cur != C_CTR_MAX) w_ctr_d = w_ctr_cur + 1'b1;
    end else begin
      if (w_ctr_cur != C_CTR_MIN) w_ctr_d = w_ctr_cur - 1'b1;
    end
    if (bus.train_valid) begin
      // A mispredict rebuilds history from the snapshot taken at lookup time
      if (bus.train_mispredicted)
        history_d = {bus.train_history[IDX_W-2:0], bus.train_taken};
      else
        history_d = {history_q[IDX_W-2:0], bus.train_taken};
    end
  end

  // Counter table: a single entry written per training request
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      table_q <= {DEPTH{C_CTR_RST}};
    end else if (bus.train_valid) begin
      table_q[w_tidx] <= w_ctr_d;
    end
  end

  // Global history register
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) history_q <= '0;
    else           history_q <= history_d;
  end

  // Registered lookup result; values hold between lookups
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      ready_q <= 1'b0;
      taken_q <= 1'b0;
      state_q <= '0;
      phist_q <= '0;
    end else begin
      ready_q <= bus.predict_valid;
      if (bus.predict_valid) begin
        state_q <= w_lookup;
        taken_q <= w_lookup[CTR_W-1];
        phist_q <= history_q;
      end
    end
  end

  assign bus.predict_ready   = ready_q;
  assign bus.predict_taken   = taken_q;
  assign bus.predict_state   = state_q;
  assign bus.predict_history = phist_q;
  assign bus.history         = history_q;

endmodule

`default_nettype wire

// File: tb/tb_bht_predictor.sv
// ============================================================================
// Module      : tb_bht_predictor
// Description : Self-checking bench for bht_predictor with a behavioural
//               reference model (integer counters and history).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bht_predictor;
  localparam int CTR_W = 2;
  localparam int IDX_W = 5;
  localparam int DEPTH = 1 << IDX_W;
  localparam int CMAX  = (1 << CTR_W) - 1;
  localparam int CRST  = (1 << (CTR_W - 1)) - 1;
  localparam int HMASK = DEPTH - 1;

  logic clk;
  logic areset_n;

  bht_predictor_if #(.CTR_W(CTR_W), .IDX_W(IDX_W)) bus ();

  bht_predictor #(.CTR_W(CTR_W), .IDX_W(IDX_W)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model
  int m_ctr [DEPTH];
  int m_hist;
  int e_ready, e_taken, e_state, e_phist;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_ctr[i] = CRST;
    m_hist  = 0;
    e_ready = 0; e_taken = 0; e_state = 0; e_phist = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ready"},   32'(bus.predict_ready),   32'(e_ready));
    check({tag, ".state"},   32'(bus.predict_state),   32'(e_state));
    check({tag, ".taken"},   32'(bus.predict_taken),   32'(e_taken));
    check({tag, ".phist"},   32'(bus.predict_history), 32'(e_phist));
    check({tag, ".history"}, 32'(bus.history),         32'(m_hist));
  endtask

  // One clock cycle with the given requests; model advanced, outputs checked
  task automatic step(input string tag, input bit pv, input int ppc,
                      input bit tv, input int tpc, input bit tt,
                      input bit tm, input int th);
    int pidx, tidx;
    bus.predict_valid      = pv;
    bus.predict_pc         = IDX_W'(ppc);
    bus.train_valid        = tv;
    bus.train_pc           = IDX_W'(tpc);
    bus.train_taken        = tt;
    bus.train_mispredicted = tm;
    bus.train_history      = IDX_W'(th);
`ifdef BHT_PREDICTOR_GSHARE_EN
    pidx = (ppc ^ m_hist) & HMASK;
    tidx = (tpc ^ th) & HMASK;
`else
    pidx = ppc & HMASK;
    tidx = tpc & HMASK;
`endif
    // Lookup sees the table as it was before this edge's training
    e_ready = pv;
    if (pv) begin
      e_state = m_ctr[pidx];
      e_taken = (m_ctr[pidx] > CRST) ? 1 : 0;
      e_phist = m_hist;
    end
    if (tv) begin
      if (tt) m_ctr[tidx] = (m_ctr[tidx] < CMAX) ? m_ctr[tidx] + 1 : CMAX;
      else    m_ctr[tidx] = (m_ctr[tidx] > 0)    ? m_ctr[tidx] - 1 : 0;
      m_hist = (((tm ? th : m_hist) * 2) + (tt ? 1 : 0)) & HMASK;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    bus.predict_valid = 0; bus.predict_pc = '0;
    bus.train_valid = 0; bus.train_pc = '0; bus.train_taken = 0;
    bus.train_mispredicted = 0; bus.train_history = '0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle();
    model_reset();
    areset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    areset_n = 1'b1;
    @(posedge clk);
    #1;

    // First lookup after reset sees weakly not-taken
    step("lookup_pc3", 1, 3, 0, 0, 0, 0, 0);
    check("lookup_pc3.lit_state", 32'(bus.predict_state), 32'd1);
    check("lookup_pc3.lit_taken", 32'(bus.predict_taken), 32'd0);
    step("idle_hold", 0, 0, 0, 0, 0, 0, 0);

    // Saturate upward then downward
    for (int i = 0; i < 5; i++) step("train_up", 0, 0, 1, 3, 1, 0, 0);
    step("sat_hi", 1, 3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("train_dn", 0, 0, 1, 3, 0, 0, 0);
    step("sat_lo", 1, 3, 0, 0, 0, 0, 0);

    // Same-cycle lookup and training of entry 7 from state 1
    step("same_cyc", 1, 7, 1, 7, 1, 0, 0);
    step("after_same", 1, 7, 0, 0, 0, 0, 0);

    // Mispredict history recovery
    step("hist_set", 0, 0, 1, 20, 0, 1, 5'b01011);
    check("hist_set.lit", 32'(bus.history), 32'b10110);
    step("hist_recover", 0, 0, 1, 21, 1, 1, 5'b00011);
    check("hist_recover.lit", 32'(bus.history), 32'b00111);
    step("hist_shift", 1, 4, 1, 22, 0, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           int'($urandom_range(0, DEPTH - 1)));
    end

    // Asynchronous reset mid-cycle while requests are pending
    bus.predict_valid = 1; bus.train_valid = 1; bus.train_taken = 1;
    #3;
    areset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    idle();
    areset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      step("post_rst", 1, i, 0, 0, 0, 0, 0);
      check("post_rst.lit", 32'(bus.predict_state), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
